// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data load/store share one memory port.
// Optional macro MEM_ARB_RR_EN switches collision handling from data-first to round-robin.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_done_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_done_o,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [3:0] WAIT_INIT = WAIT_CYCLES[3:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    state_t      state_q;
    owner_t      owner_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] rdata_q;
    logic        if_done_q;
    logic        d_done_q;
    logic        busy_q;
    logic        mem_en_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        grant_data_d;

`ifdef MEM_ARB_RR_EN
    owner_t      last_q;

    // Reset value "data granted last" makes fetch win the first collision.
    always_comb begin
        grant_data_d = d_req_i;
        if (d_req_i && if_req_i) begin
            grant_data_d = (last_q == OWN_FETCH);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            last_q <= OWN_DATA;
        end else if (state_q == S_IDLE && (if_req_i || d_req_i)) begin
            last_q <= grant_data_d ? OWN_DATA : OWN_FETCH;
        end
    end
`else
    always_comb begin
        grant_data_d = d_req_i;
    end
`endif

    // The memory-side address/data registers double as the transaction latch:
    // loaded on grant, held through BUSY, cleared on leaving BUSY.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_FETCH;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            rdata_q     <= 32'h0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if_done_q <= 1'b0;
                    d_done_q  <= 1'b0;
                    if (if_req_i || d_req_i) begin
                        state_q     <= S_BUSY;
                        owner_q     <= grant_data_d ? OWN_DATA : OWN_FETCH;
                        cnt_q       <= WAIT_INIT;
                        we_q        <= grant_data_d & d_we_i;
                        busy_q      <= 1'b1;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= grant_data_d && d_we_i && (WAIT_INIT == 4'd0);
                        mem_addr_q  <= grant_data_d ? d_addr_i : if_addr_i;
                        mem_wdata_q <= grant_data_d ? d_wdata_i : 32'h0;
                    end else begin
                        busy_q      <= 1'b0;
                        mem_en_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= 32'h0;
                        mem_wdata_q <= 32'h0;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= S_DONE;
                        mem_en_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= 32'h0;
                        mem_wdata_q <= 32'h0;
                        if (!we_q) begin
                            rdata_q <= mem_rdata_i;
                        end
                        if_done_q   <= (owner_q == OWN_FETCH);
                        d_done_q    <= (owner_q == OWN_DATA);
                    end else begin
                        cnt_q    <= cnt_q - 4'd1;
                        mem_we_q <= we_q && (cnt_q == 4'd1);
                    end
                end
                S_DONE: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    if_done_q <= 1'b0;
                    d_done_q  <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    cnt_q       <= 4'd0;
                    if_done_q   <= 1'b0;
                    d_done_q    <= 1'b0;
                    busy_q      <= 1'b0;
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= 32'h0;
                    mem_wdata_q <= 32'h0;
                end
            endcase
        end
    end

    assign if_done_o   = if_done_q;
    assign d_done_o    = d_done_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = busy_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four instances (WAIT_CYCLES 0,1,2,15) checked one after another
// against a transaction-timeline reference model; honours MEM_ARB_RR_EN.
module tb_mem_arbiter;

    localparam int NU = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n_v   [NU];
    logic        if_req_v    [NU];
    logic        d_req_v     [NU];
    logic        d_we_v      [NU];
    logic        if_done_v   [NU];
    logic        d_done_v    [NU];
    logic        busy_v      [NU];
    logic        mem_en_v    [NU];
    logic        mem_we_v    [NU];
    logic [31:0] if_addr_v   [NU];
    logic [31:0] d_addr_v    [NU];
    logic [31:0] d_wdata_v   [NU];
    logic [31:0] mem_rdata_v [NU];
    logic [31:0] rdata_v     [NU];
    logic [31:0] mem_addr_v  [NU];
    logic [31:0] mem_wdata_v [NU];

    for (genvar gi = 0; gi < NU; gi++) begin : g_dut
        mem_arbiter #(.WAIT_CYCLES((gi == 3) ? 15 : gi)) dut (
            .clk_i       (clk),
            .reset_ni    (reset_n_v[gi]),
            .if_req_i    (if_req_v[gi]),
            .if_addr_i   (if_addr_v[gi]),
            .if_done_o   (if_done_v[gi]),
            .d_req_i     (d_req_v[gi]),
            .d_we_i      (d_we_v[gi]),
            .d_addr_i    (d_addr_v[gi]),
            .d_wdata_i   (d_wdata_v[gi]),
            .d_done_o    (d_done_v[gi]),
            .rdata_o     (rdata_v[gi]),
            .busy_o      (busy_v[gi]),
            .mem_en_o    (mem_en_v[gi]),
            .mem_we_o    (mem_we_v[gi]),
            .mem_addr_o  (mem_addr_v[gi]),
            .mem_wdata_o (mem_wdata_v[gi]),
            .mem_rdata_i (mem_rdata_v[gi])
        );
    end

    int total = 0;
    int bad   = 0;
    int lcyc  = 0;
    logic [1:0] u;
    int W;

    // Reference model: a granted transaction is described by the number of
    // cycles elapsed since grant (m_t); all outputs follow from that.
    bit          m_act;
    int          m_t;
    bit          m_data;
    bit          m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
`ifdef MEM_ARB_RR_EN
    bit          m_last_data;
`endif

    bit seen_if, seen_d;
    int we_cnt, we_at;
    bit order_q[$];

    function automatic int wait_of(input logic [1:0] k);
        return (k == 2'd3) ? 15 : int'(k);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s unit=%0d cyc=%0d observed=%h expected=%h", tag, u, lcyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_act = 1'b0; m_t = 0; m_data = 1'b0; m_we = 1'b0;
        m_addr = 32'h0; m_wdata = 32'h0; m_rdata = 32'h0;
`ifdef MEM_ARB_RR_EN
        m_last_data = 1'b1;
`endif
    endtask

    task automatic model_update();
        bit pick_d;
        if (m_act) begin
            if (m_t == W + 1 && !m_we) m_rdata = mem_rdata_v[u];
            m_t++;
            if (m_t == W + 3) m_act = 1'b0;
        end else if (if_req_v[u] || d_req_v[u]) begin
`ifdef MEM_ARB_RR_EN
            pick_d = d_req_v[u] && (!if_req_v[u] || !m_last_data);
            m_last_data = pick_d;
`else
            pick_d = d_req_v[u];
`endif
            m_act   = 1'b1;
            m_t     = 1;
            m_data  = pick_d;
            m_we    = pick_d && d_we_v[u];
            m_addr  = pick_d ? d_addr_v[u] : if_addr_v[u];
            m_wdata = pick_d ? d_wdata_v[u] : 32'h0;
        end
    endtask

    task automatic check_outputs();
        bit en;
        en = m_act && (m_t <= W + 1);
        chk("busy",      32'(busy_v[u]),    32'(m_act));
        chk("mem_en",    32'(mem_en_v[u]),  32'(en));
        chk("mem_we",    32'(mem_we_v[u]),  32'(en && m_we && m_t == W + 1));
        chk("mem_addr",  mem_addr_v[u],     en ? m_addr : 32'h0);
        chk("mem_wdata", mem_wdata_v[u],    en ? m_wdata : 32'h0);
        chk("if_done",   32'(if_done_v[u]), 32'(m_act && m_t == W + 2 && !m_data));
        chk("d_done",    32'(d_done_v[u]),  32'(m_act && m_t == W + 2 && m_data));
        chk("rdata",     rdata_v[u],        m_rdata);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        lcyc++;
        check_outputs();
        seen_if = if_done_v[u];
        seen_d  = d_done_v[u];
        if (mem_we_v[u]) begin
            we_cnt++;
            we_at = lcyc;
        end
        if (seen_if) if_req_v[u] = 1'b0;
        if (seen_d)  d_req_v[u]  = 1'b0;
        if (seen_if || seen_d) order_q.push_back(seen_d);
    endtask

    task automatic wait_done(input bit want_d, output int at);
        at = -1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (want_d ? seen_d : seen_if) begin
                at = lcyc;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset_n_v[u] = 1'b0;
        if_req_v[u] = 1'b0; d_req_v[u] = 1'b0; d_we_v[u] = 1'b0;
        if_addr_v[u] = 32'h0; d_addr_v[u] = 32'h0; d_wdata_v[u] = 32'h0;
        mem_rdata_v[u] = 32'h0;
        model_reset();
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        reset_n_v[u] = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, at;
        int rem_if, rem_d;
        for (int k = 0; k < NU; k++) begin
            reset_n_v[k] = 1'b0; if_req_v[k] = 1'b0; d_req_v[k] = 1'b0; d_we_v[k] = 1'b0;
            if_addr_v[k] = 32'h0; d_addr_v[k] = 32'h0; d_wdata_v[k] = 32'h0; mem_rdata_v[k] = 32'h0;
        end
        u = 2'd0;
        W = 0;
        model_reset();
        @(negedge clk);

        for (int k = 0; k < NU; k++) begin
            u = 2'(k);
            W = wait_of(u);
            do_reset();

            // fetch read
            if_addr_v[u] = 32'h0000_0010; mem_rdata_v[u] = 32'h00A0_0093; if_req_v[u] = 1'b1;
            start = lcyc;
            wait_done(1'b0, at);
            chk("fetch_latency", 32'(at - start), 32'(W + 2));
            chk("fetch_rdata", rdata_v[u], 32'h00A0_0093);
            tick();

            // store: single write strobe in last busy cycle, rdata untouched
            d_addr_v[u] = 32'h0000_0100; d_wdata_v[u] = 32'hDEAD_BEEF; d_we_v[u] = 1'b1;
            mem_rdata_v[u] = 32'h5555_5555; d_req_v[u] = 1'b1;
            we_cnt = 0; we_at = -1; start = lcyc;
            wait_done(1'b1, at);
            chk("store_latency", 32'(at - start), 32'(W + 2));
            chk("store_we_count", 32'(we_cnt), 32'd1);
            chk("store_we_cycle", 32'(we_at - start), 32'(W + 1));
            chk("store_rdata", rdata_v[u], 32'h00A0_0093);
            tick();

            // load, with a fetch arriving during BUSY that waits for the next IDLE
            d_we_v[u] = 1'b0; d_addr_v[u] = 32'h0000_0200; mem_rdata_v[u] = 32'h1234_5678;
            d_req_v[u] = 1'b1; start = lcyc;
            tick();
            if_addr_v[u] = 32'h0000_0040; if_req_v[u] = 1'b1;
            wait_done(1'b1, at);
            chk("load_latency", 32'(at - start), 32'(W + 2));
            chk("load_rdata", rdata_v[u], 32'h1234_5678);
            mem_rdata_v[u] = 32'hCAFE_F00D;
            wait_done(1'b0, at);
            chk("late_fetch_latency", 32'(at - start), 32'(2 * W + 5));
            chk("late_fetch_rdata", rdata_v[u], 32'hCAFE_F00D);
            tick();

            // two back-to-back collisions straight after reset
            do_reset();
            order_q.delete();
            mem_rdata_v[u] = 32'h7777_7777;
            if_addr_v[u] = 32'h0000_0080; d_addr_v[u] = 32'h0000_0300; d_we_v[u] = 1'b0;
            if_req_v[u] = 1'b1; d_req_v[u] = 1'b1;
            rem_if = 2; rem_d = 2;
            for (int i = 0; i < 200 && order_q.size() < 4; i++) begin
                tick();
                if (seen_if) rem_if--;
                else if (!if_req_v[u] && rem_if > 0) if_req_v[u] = 1'b1;
                if (seen_d) rem_d--;
                else if (!d_req_v[u] && rem_d > 0) d_req_v[u] = 1'b1;
            end
            chk("collision_count", 32'(order_q.size()), 32'd4);
            for (int i = order_q.size(); i < 4; i++) order_q.push_back(1'b0);
`ifdef MEM_ARB_RR_EN
            chk("order0", 32'(order_q[0]), 32'd0);
            chk("order1", 32'(order_q[1]), 32'd1);
            chk("order2", 32'(order_q[2]), 32'd0);
            chk("order3", 32'(order_q[3]), 32'd1);
`else
            chk("order0", 32'(order_q[0]), 32'd1);
            chk("order1", 32'(order_q[1]), 32'd1);
            chk("order2", 32'(order_q[2]), 32'd0);
            chk("order3", 32'(order_q[3]), 32'd0);
`endif
            tick();

            // reset in the middle of a store
            if (W >= 1) begin
                d_addr_v[u] = 32'h0000_0104; d_wdata_v[u] = 32'h0BAD_F00D; d_we_v[u] = 1'b1;
                d_req_v[u] = 1'b1; we_cnt = 0; order_q.delete();
                tick();
                chk("abort_in_busy", 32'(busy_v[u]), 32'd1);
                reset_n_v[u] = 1'b0;
                d_req_v[u] = 1'b0;
                model_reset();
                #1;
                chk("abort_busy_now", 32'(busy_v[u]), 32'd0);
                chk("abort_rdata_now", rdata_v[u], 32'h0);
                check_outputs();
                @(negedge clk);
                check_outputs();
                reset_n_v[u] = 1'b1;
                for (int i = 0; i < W + 4; i++) tick();
                chk("abort_we_seen", 32'(we_cnt), 32'd0);
                chk("abort_done_seen", 32'(order_q.size()), 32'd0);
            end

            // randomized traffic
            do_reset();
            for (int i = 0; i < 150 + 6 * W; i++) begin
                tick();
                mem_rdata_v[u] = $urandom;
                if (!if_req_v[u] && !seen_if && $urandom_range(0, 2) == 0) begin
                    if_addr_v[u] = $urandom;
                    if_req_v[u] = 1'b1;
                end
                if (!d_req_v[u] && !seen_d && $urandom_range(0, 2) == 0) begin
                    d_addr_v[u]  = $urandom;
                    d_wdata_v[u] = $urandom;
                    d_we_v[u]    = 1'($urandom_range(0, 1));
                    d_req_v[u]   = 1'b1;
                end
            end
            reset_n_v[u] = 1'b0;
            if_req_v[u] = 1'b0;
            d_req_v[u] = 1'b0;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
